// File: rtl/ndp_timeout_pkg.sv
// ndp_timeout_pkg: shared widths, defaults, FSM encoding and arm payload for
// the multi-flow NDP timeout engine.
// Width macros TIME_W, TIMER_W and FLOW_SEQ_NUM_W may be supplied by the build.
// When they are not supplied, the defaults below are used.
// Optional feature macro: NDP_TIMEOUT_RTX_LIMIT_EN (retry limit / abort).

`ifndef TIME_W
`define TIME_W 32
`endif
`ifndef TIMER_W
`define TIMER_W 16
`endif
`ifndef FLOW_SEQ_NUM_W
`define FLOW_SEQ_NUM_W 32
`endif

package ndp_timeout_pkg;

    // Smallest width able to index n distinct values (minimum 1)
    function automatic int unsigned clogb2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w = w + 1;
        return w;
    endfunction

    localparam int unsigned TIME_W          = `TIME_W;
    localparam int unsigned TIMER_W         = `TIMER_W;
    localparam int unsigned SEQ_W           = `FLOW_SEQ_NUM_W;
    localparam int unsigned DEF_NUM_FLOWS   = 16;
    localparam int unsigned DEF_MAX_BACKOFF = 6;
    localparam int unsigned DEF_MAX_RETRIES = 8;
    localparam int unsigned DEF_BACKOFF_W   = clogb2(DEF_MAX_BACKOFF + 1);

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Per-flow data recorded by an arm request
    typedef struct packed {
        logic [SEQ_W-1:0]   wnd_start;
        logic [SEQ_W-1:0]   next_new;
        logic [TIMER_W-1:0] base_amnt;
    } arm_payload_t;

endpackage

// File: rtl/ndp_timeout_flow_table.sv
// ndp_timeout_flow_table: flop-based per-flow timer table.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   now                         current time, used to compute the arm deadline
//   arm_*                       external arm (records payload, clears backoff)
//   disarm_*                    external disarm (clears armed only)
//   scan_*                      scanner re-arm write (lowest priority)
//   rd_idx, rd_*_c              combinational read of one entry
// Disarm beats arm, and either external write beats the scanner on the same index.
// With NDP_TIMEOUT_RTX_LIMIT_EN each entry also carries a retry counter.

module ndp_timeout_flow_table
    import ndp_timeout_pkg::*;
#(
    parameter int unsigned NUM_FLOWS = DEF_NUM_FLOWS,
    parameter int unsigned FLOW_ID_W = clogb2(NUM_FLOWS),
    parameter int unsigned BACKOFF_W = DEF_BACKOFF_W
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
    ,
    parameter int unsigned RETRY_W   = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TIME_W-1:0]    now,
    input  logic                 arm_valid,
    input  logic [FLOW_ID_W-1:0] arm_flow_id,
    input  arm_payload_t         arm_payload,
    input  logic                 disarm_valid,
    input  logic [FLOW_ID_W-1:0] disarm_flow_id,
    input  logic                 scan_we,
    input  logic [FLOW_ID_W-1:0] scan_idx,
    input  logic                 scan_armed,
    input  logic [TIME_W-1:0]    scan_deadline,
    input  logic [BACKOFF_W-1:0] scan_backoff,
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
    input  logic [RETRY_W-1:0]   scan_retries,
    output logic [RETRY_W-1:0]   rd_retries_c,
`endif
    input  logic [FLOW_ID_W-1:0] rd_idx,
    output logic                 rd_armed_c,
    output logic [TIME_W-1:0]    rd_deadline_c,
    output arm_payload_t         rd_payload_c,
    output logic [BACKOFF_W-1:0] rd_backoff_c
);

    logic                 armed_q    [NUM_FLOWS];
    logic [TIME_W-1:0]    deadline_q [NUM_FLOWS];
    arm_payload_t         payload_q  [NUM_FLOWS];
    logic [BACKOFF_W-1:0] backoff_q  [NUM_FLOWS];
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
    logic [RETRY_W-1:0]   retries_q  [NUM_FLOWS];
`endif

    // Entry update with disarm > arm > scanner priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                armed_q[i]    <= 1'b0;
                deadline_q[i] <= '0;
                payload_q[i]  <= '0;
                backoff_q[i]  <= '0;
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
                retries_q[i]  <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (disarm_valid && disarm_flow_id == FLOW_ID_W'(i)) begin
                    armed_q[i] <= 1'b0;
                end else if (arm_valid && arm_flow_id == FLOW_ID_W'(i)) begin
                    armed_q[i]    <= 1'b1;
                    deadline_q[i] <= now + TIME_W'(arm_payload.base_amnt);
                    payload_q[i]  <= arm_payload;
                    backoff_q[i]  <= '0;
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
                    retries_q[i]  <= '0;
`endif
                end else if (scan_we && scan_idx == FLOW_ID_W'(i)) begin
                    armed_q[i]    <= scan_armed;
                    deadline_q[i] <= scan_deadline;
                    backoff_q[i]  <= scan_backoff;
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
                    retries_q[i]  <= scan_retries;
`endif
                end
            end
        end
    end

    assign rd_armed_c    = armed_q[rd_idx];
    assign rd_deadline_c = deadline_q[rd_idx];
    assign rd_payload_c  = payload_q[rd_idx];
    assign rd_backoff_c  = backoff_q[rd_idx];
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
    assign rd_retries_c  = retries_q[rd_idx];
`endif

endmodule

// File: rtl/ndp_timeout_engine.sv
// ndp_timeout_engine: multi-flow NDP retransmit timer.
// The engine scans the flow table round-robin against `now`. When a flow
// expires, it presents a retransmit event over valid/ready. When the event is
// accepted, the engine re-arms the flow with exponential backoff.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   now               free-running time (wraps mod 2^TIME_W)
//   arm_*             arm/re-arm request from the ack/send path
//   disarm_*          disarm request from the ack/send path
//   evt_*             timeout event to the retransmit scheduler
// Optional feature macro: NDP_TIMEOUT_RTX_LIMIT_EN. When it is defined, the
// event on the MAX_RETRIES-th consecutive expiry carries evt_abort. That
// event's acceptance disarms the flow instead of re-arming it.

module ndp_timeout_engine
    import ndp_timeout_pkg::*;
#(
    parameter int unsigned NUM_FLOWS   = DEF_NUM_FLOWS,
    parameter int unsigned FLOW_ID_W   = clogb2(NUM_FLOWS),
    parameter int unsigned MAX_BACKOFF = DEF_MAX_BACKOFF
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
    ,
    parameter int unsigned MAX_RETRIES = DEF_MAX_RETRIES
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [TIME_W-1:0]              now,
    input  logic                           arm_valid,
    input  logic [FLOW_ID_W-1:0]           arm_flow_id,
    input  logic [SEQ_W-1:0]               arm_wnd_start,
    input  logic [SEQ_W-1:0]               arm_next_new,
    input  logic [TIMER_W-1:0]             arm_timer_amnt,
    input  logic                           disarm_valid,
    input  logic [FLOW_ID_W-1:0]           disarm_flow_id,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [FLOW_ID_W-1:0]           evt_flow_id,
    output logic [SEQ_W-1:0]               evt_rtx_start,
    output logic [SEQ_W-1:0]               evt_rtx_end,
    output logic [TIMER_W+MAX_BACKOFF-1:0] evt_timer_amnt,
    output logic                           evt_abort
);

    localparam int unsigned BACKOFF_W = clogb2(MAX_BACKOFF + 1);
    localparam int unsigned AMNT_W    = TIMER_W + MAX_BACKOFF;
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
    localparam int unsigned RETRY_W   = clogb2(MAX_RETRIES + 1);
`endif

    state_e               state_q, state_n;
    logic [FLOW_ID_W-1:0] ptr_q, ptr_n;
    logic                 ext_hit_q, ext_hit_n;
    logic                 evt_valid_n;
    logic [FLOW_ID_W-1:0] evt_flow_id_n;
    logic [SEQ_W-1:0]     evt_rtx_start_n, evt_rtx_end_n;
    logic [AMNT_W-1:0]    evt_timer_amnt_n;

    arm_payload_t         arm_payload_c;
    logic                 rd_armed_c;
    logic [TIME_W-1:0]    rd_deadline_c;
    arm_payload_t         rd_payload_c;
    logic [BACKOFF_W-1:0] rd_backoff_c;
    logic [TIME_W-1:0]    since_deadline_c;
    logic                 expired_c;
    logic                 ext_hit_now_c;
    logic                 scan_we_c;
    logic                 scan_armed_c;
    logic [TIME_W-1:0]    scan_deadline_c;
    logic [BACKOFF_W-1:0] scan_backoff_c;
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
    logic                 evt_abort_n;
    logic [RETRY_W-1:0]   rd_retries_c;
    logic [RETRY_W-1:0]   scan_retries_c;
`endif

    assign arm_payload_c = '{wnd_start: arm_wnd_start,
                             next_new:  arm_next_new,
                             base_amnt: arm_timer_amnt};

    ndp_timeout_flow_table #(
        .NUM_FLOWS      (NUM_FLOWS),
        .FLOW_ID_W      (FLOW_ID_W),
        .BACKOFF_W      (BACKOFF_W)
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
        ,
        .RETRY_W        (RETRY_W)
`endif
    ) u_table (
        .clk            (clk),
        .rst_n          (rst_n),
        .now            (now),
        .arm_valid      (arm_valid),
        .arm_flow_id    (arm_flow_id),
        .arm_payload    (arm_payload_c),
        .disarm_valid   (disarm_valid),
        .disarm_flow_id (disarm_flow_id),
        .scan_we        (scan_we_c),
        .scan_idx       (ptr_q),
        .scan_armed     (scan_armed_c),
        .scan_deadline  (scan_deadline_c),
        .scan_backoff   (scan_backoff_c),
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
        .scan_retries   (scan_retries_c),
        .rd_retries_c   (rd_retries_c),
`endif
        .rd_idx         (ptr_q),
        .rd_armed_c     (rd_armed_c),
        .rd_deadline_c  (rd_deadline_c),
        .rd_payload_c   (rd_payload_c),
        .rd_backoff_c   (rd_backoff_c)
    );

    // Wrap-safe expiry: the deadline has passed when (now - deadline) is non-negative
    assign since_deadline_c = now - rd_deadline_c;
    assign expired_c        = rd_armed_c && !since_deadline_c[TIME_W-1];
    assign ext_hit_now_c    = (arm_valid && arm_flow_id == ptr_q) ||
                              (disarm_valid && disarm_flow_id == ptr_q);

    // Next-state, event capture and scanner re-arm
    always_comb begin
        state_n          = state_q;
        ptr_n            = ptr_q;
        ext_hit_n        = ext_hit_q;
        evt_valid_n      = evt_valid;
        evt_flow_id_n    = evt_flow_id;
        evt_rtx_start_n  = evt_rtx_start;
        evt_rtx_end_n    = evt_rtx_end;
        evt_timer_amnt_n = evt_timer_amnt;
        scan_we_c        = 1'b0;
        scan_deadline_c  = now + TIME_W'(evt_timer_amnt);
        scan_backoff_c   = (rd_backoff_c >= BACKOFF_W'(MAX_BACKOFF)) ?
                           BACKOFF_W'(MAX_BACKOFF) : rd_backoff_c + BACKOFF_W'(1);
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
        evt_abort_n      = evt_abort;
        scan_armed_c     = !evt_abort;
        scan_retries_c   = (rd_retries_c == RETRY_W'(MAX_RETRIES)) ?
                           rd_retries_c : rd_retries_c + RETRY_W'(1);
`else
        scan_armed_c     = 1'b1;
`endif

        case (state_q)
            SCAN: begin
                // A same-cycle arm/disarm to this flow supersedes the expiry
                if (expired_c && !ext_hit_now_c) begin
                    state_n          = EMIT;
                    ext_hit_n        = 1'b0;
                    evt_valid_n      = 1'b1;
                    evt_flow_id_n    = ptr_q;
                    evt_rtx_start_n  = rd_payload_c.wnd_start;
                    evt_rtx_end_n    = rd_payload_c.next_new;
                    evt_timer_amnt_n = AMNT_W'(rd_payload_c.base_amnt) << rd_backoff_c;
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
                    evt_abort_n      = (rd_retries_c == RETRY_W'(MAX_RETRIES - 1));
`endif
                end else begin
                    ptr_n = ptr_q + FLOW_ID_W'(1);
                end
            end
            EMIT: begin
                // Remember any external write so the stale re-arm is skipped
                if (ext_hit_now_c) begin
                    ext_hit_n = 1'b1;
                end
                if (evt_ready) begin
                    scan_we_c   = !(ext_hit_q || ext_hit_now_c);
                    evt_valid_n = 1'b0;
                    ext_hit_n   = 1'b0;
                    ptr_n       = ptr_q + FLOW_ID_W'(1);
                    state_n     = SCAN;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    // State and registered event outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SCAN;
            ptr_q          <= '0;
            ext_hit_q      <= 1'b0;
            evt_valid      <= 1'b0;
            evt_flow_id    <= '0;
            evt_rtx_start  <= '0;
            evt_rtx_end    <= '0;
            evt_timer_amnt <= '0;
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
            evt_abort      <= 1'b0;
`endif
        end else begin
            state_q        <= state_n;
            ptr_q          <= ptr_n;
            ext_hit_q      <= ext_hit_n;
            evt_valid      <= evt_valid_n;
            evt_flow_id    <= evt_flow_id_n;
            evt_rtx_start  <= evt_rtx_start_n;
            evt_rtx_end    <= evt_rtx_end_n;
            evt_timer_amnt <= evt_timer_amnt_n;
`ifdef NDP_TIMEOUT_RTX_LIMIT_EN
            evt_abort      <= evt_abort_n;
`endif
        end
    end

`ifndef NDP_TIMEOUT_RTX_LIMIT_EN
    assign evt_abort = 1'b0;
`endif

endmodule
